// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: N-to-1 mux (explicit select or round-robin) with one registered valid/ready output stage
//   in_data/in_valid/in_ready : NUM_IN packed sources and their handshake
//   mode/sel                  : 0 = take source sel, 1 = round-robin among valid sources
//   out_data/out_src/out_valid/out_ready : registered word, its source index, downstream handshake
module mux_nto1_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] src_q, src_d, ptr_q, ptr_d, rr_g, g;
  logic valid_q, valid_d, load, rr_v, gnt_v, xfer;
  // walk from the farthest candidate to the nearest so the nearest valid one wins
  always_comb begin
    rr_v = 1'b0;
    rr_g = '0;
    for (int k = NUM_IN; k >= 1; k--)
      if (|(in_valid & (NUM_IN'(1) << ((int'(ptr_q) + k) % NUM_IN)))) begin
        rr_v = 1'b1;
        rr_g = SEL_W'((int'(ptr_q) + k) % NUM_IN);
      end
  end
  assign load     = !valid_q || out_ready;
  assign g        = mode ? rr_g : sel;
  assign gnt_v    = mode ? rr_v : (int'(sel) < NUM_IN);
  assign in_ready = (load && gnt_v) ? NUM_IN'(1) << g : '0;
  assign xfer     = |(in_valid & in_ready);
  always_comb begin
    data_d  = xfer ? WIDTH'(in_data >> (int'(g) * WIDTH)) : data_q;
    src_d   = xfer ? g : src_q;
    valid_d = xfer || (valid_q && !out_ready);
    ptr_d   = (xfer && mode) ? g : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= SEL_W'(NUM_IN - 1);
    end else begin
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_valid = valid_q;
endmodule
